// File: rtl/pc_sequencer_pkg.sv
// Shared types and default widths for the program-counter sequencer.
// Imported by the interface, the branch LUT and the top.
package seq_pkg;

    localparam int PW_DEF = 10;
    localparam int LW_DEF = 5;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL,
        HALT
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/ALU-facing bundle of the sequencer.
// The master drives launch, branch, stall and LUT-write; the slave returns fetch status.
interface pc_sequencer_if
    import seq_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int LW = LW_DEF,
    parameter int CW = CW_DEF
) ();

    logic          start;
    logic [PW-1:0] start_addr;
    logic          branch_en;
    logic          branch_taken;
    logic [LW-1:0] branch_idx;
    logic          stall;
    logic          halt;
    logic          lut_we;
    logic [LW-1:0] lut_waddr;
    logic [PW-1:0] lut_wdata;
    logic [PW-1:0] prog_ctr;
    logic          instr_valid;
    logic          done;
    logic          err;
    logic [CW-1:0] cycle_cnt;

    modport master (
        output start, start_addr,
        output branch_en, branch_taken, branch_idx,
        output stall, halt,
        output lut_we, lut_waddr, lut_wdata,
        input  prog_ctr, instr_valid,
        input  done, err, cycle_cnt
    );

    modport slave (
        input  start, start_addr,
        input  branch_en, branch_taken, branch_idx,
        input  stall, halt,
        input  lut_we, lut_waddr, lut_wdata,
        output prog_ctr, instr_valid,
        output done, err, cycle_cnt
    );

endinterface

// File: rtl/pc_sequencer_branch_lut.sv
// Branch-target table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; a same-cycle read returns the old entry.
module branch_lut
    import seq_pkg::*;
#(
    parameter int LW = LW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [LW-1:0] waddr,
    input  logic [PW-1:0] wdata,
    input  logic [LW-1:0] raddr,
    output logic [PW-1:0] rdata
);

    logic [PW-1:0] mem_q [2**LW];

    // Write the addressed entry on lut_we
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: launch, sequential fetch, taken
// branches via LUT, stall/halt handling, run-off detection and cycle count.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int LW = LW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    localparam logic [PW-1:0] PC_LAST = '1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    seq_state_e    state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] lut_target;
    logic          take_br;

    branch_lut #(
        .LW (LW),
        .PW (PW)
    ) u_lut (
        .clk   (clk),
        .we    (bus.lut_we),
        .waddr (bus.lut_waddr),
        .wdata (bus.lut_wdata),
        .raddr (bus.branch_idx),
        .rdata (lut_target)
    );

    assign take_br = bus.branch_en & bus.branch_taken;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: halt beats stall, stall beats branch, branch beats run-off
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                if (bus.halt)               state_d = HALT;
                else if (bus.stall)         state_d = STALL;
                else if (take_br)           state_d = RUN;
                else if (pc_q == PC_LAST)   state_d = HALT;
                else                        state_d = RUN;
            end
            STALL: begin
                if (!bus.stall) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: PC, done/err flags and saturating cycle count
    always_comb begin
        pc_d   = pc_q;
        done_d = done_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    pc_d   = bus.start_addr;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    cnt_d  = '0;
                end
            end
            RUN: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                if (bus.halt) begin
                    done_d = 1'b1;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (take_br) begin
                    pc_d = lut_target;
                end else if (pc_q == PC_LAST) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    pc_d = pc_q + PW'(1);
                end
            end
            STALL: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
            end
            default: pc_d = pc_q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            done_q <= done_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.prog_ctr    = pc_q;
    assign bus.instr_valid = (state_q == RUN);
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.cycle_cnt   = cnt_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter and fetch sequencer that replaces hand-driven instruction stepping. It sits between Control/ALU and instr_ROM. It generates prog_ctr, handles sequential fetch, table-driven taken branches, stalls and halts, and raises done. It also keeps a cycle counter for benchmark runs and can launch any program from a supplied start address.

Parameters:
PW, 10, prog_ctr width in bits
LW, 5, branch-target LUT index width; LUT depth is 2**LW
CW, 16, cycle counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  launch pulse, honoured only in IDLE or HALT
start_addr  in  PW  first instruction address for the launch
branch_en  in  1  Control Branch decode for the current instruction
branch_taken  in  1  ALU branch condition result
branch_idx  in  LW  branch-target LUT index from mach_code
stall  in  1  hold the current instruction (multi-cycle memory)
halt  in  1  halt instruction decoded
lut_we  in  1  LUT write enable
lut_waddr  in  LW  LUT write index
lut_wdata  in  PW  LUT write data (absolute target)
prog_ctr  out  PW  instruction address to instr_ROM
instr_valid  out  1  current mach_code is to be executed this cycle
done  out  1  program finished
err  out  1  program counter ran off the end of ROM
cycle_cnt  out  CW  cycles spent in RUN+STALL for the last launch

Behaviour:
- States: IDLE, RUN, STALL, HALT. All outputs are registered or decoded from state only, with no input-to-output combinational paths.
- Reset (async, any time, including mid-program): state=IDLE, prog_ctr=0, done=0, err=0, cycle_cnt=0, instr_valid=0. LUT contents are not reset.
- instr_valid = (state==RUN).
- IDLE or HALT with start=1: next cycle state=RUN, prog_ctr=start_addr, done=0, err=0, cycle_cnt=0. In RUN or STALL, start is ignored.
- RUN, priority order, evaluated each clock:
  1. halt=1: state=HALT, done=1, prog_ctr holds.
  2. stall=1: state=STALL, prog_ctr holds.
  3. branch_en & branch_taken: prog_ctr=lut[branch_idx].
  4. prog_ctr == 2**PW-1: state=HALT, done=1, err=1, prog_ctr holds.
  5. Otherwise prog_ctr=prog_ctr+1.
- branch_en=1 with branch_taken=0 falls through to sequential increment.
- STALL: prog_ctr holds. When stall=0, state returns to RUN and the same instruction is re-issued; its branch/halt is evaluated then. While stall=1, state stays STALL.
- cycle_cnt: increments by 1 on every clock spent in RUN or STALL, saturates at 2**CW-1 with no wrap. It holds in IDLE and HALT.
- LUT: written on lut_we in any state. If a taken branch reads the entry being written in the same cycle, it gets the old value (read-before-write).
- done and err stay asserted through HALT until the next accepted start or a reset.

Decomposition:
- Package seq_pkg holds the state enum (IDLE, RUN, STALL, HALT) and default widths PW_DEF=10, LW_DEF=5, CW_DEF=16.
- One sub-module, branch_lut: 2**LW x PW register array with one sync write port and one async read port.

Test Plan:
- Reset then start, start_addr=0x010, no branch/halt for 4 cycles, then halt -> prog_ctr 0x010,0x011,0x012,0x013,0x014; done=1 on the cycle after halt; cycle_cnt=5.
- Write lut[3]=0x100; in RUN, branch_en=1, branch_taken=1, branch_idx=3 -> next prog_ctr=0x100. Repeat with branch_taken=0 -> prog_ctr+1.
- At prog_ctr=0x020, stall high for 3 cycles -> prog_ctr holds 0x020; instr_valid=0 for 3 cycles, then 1; cycle_cnt counts stall cycles.
- start_addr=0x3FE, no branches -> 0x3FE, 0x3FF, then HALT with done=1 and err=1; prog_ctr stays 0x3FF.
- Assert halt and stall together -> HALT is taken (halt wins). Then pulse start with start_addr=0x000 -> done/err clear and prog_ctr=0x000 next cycle.
- Assert reset asynchronously mid-STALL between clock edges -> all outputs 0 immediately. A start pulse during RUN is ignored (prog_ctr unaffected).
